// File: rtl/arith_pkg.sv
// Shared types and defaults for the arithmetic block set.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage : arith_pkg

// File: rtl/ripple_subtractor.sv
// N-bit ripple subtractor (a - b - borrow_in) built from full-subtractor cells,
// the borrow counterpart of the ripple-carry adder.
module ripple_subtractor #(
    parameter int N = 5
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         borrow_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_o
);

    logic [N:0] borrow_s;

    assign borrow_s[0] = borrow_i;

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign diff_o[i]       = a_i[i] ^ b_i[i] ^ borrow_s[i];
        assign borrow_s[i + 1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow_s[i]);
    end

    assign borrow_o = borrow_s[N];

endmodule : ripple_subtractor

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock through a
// ripple subtractor, with a start/busy/done handshake.
module seq_restoring_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic             borrow_s;

    // The partial remainder never exceeds 2*divisor-1, so WIDTH+1 bits suffice.
    assign shifted_s = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    ripple_subtractor #(
        .N(WIDTH + 1)
    ) u_sub (
        .a_i     (shifted_s),
        .b_i     ({1'b0, dsr_q}),
        .borrow_i(1'b0),
        .diff_o  (trial_s),
        .borrow_o(borrow_s)
    );

    // Next-state and datapath update for the IDLE/CALC/DONE controller.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        dz_d    = dz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dsr_d  = divisor;
                    q_d    = dividend;
                    r_d    = {(WIDTH + 1){1'b0}};
                    cnt_d  = {CW{1'b0}};
                    done_d = 1'b0;
                    dz_d   = 1'b0;
                    if (divisor == {WIDTH{1'b0}}) begin
                        // Divide by zero resolves immediately without iterating.
                        state_d = DONE;
                        q_d     = {WIDTH{1'b1}};
                        r_d     = {1'b0, dividend};
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (borrow_s) begin
                    r_d = shifted_s;
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end else begin
                    r_d = trial_s;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = CALC;
                end
            end
            default: begin
                state_d = IDLE;
                q_d     = {WIDTH{1'b0}};
                r_d     = {(WIDTH + 1){1'b0}};
                cnt_d   = {CW{1'b0}};
                busy_d  = 1'b0;
                done_d  = 1'b0;
                dz_d    = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= {WIDTH{1'b0}};
            r_q     <= {(WIDTH + 1){1'b0}};
            dsr_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign quotient  = q_q;
    assign remainder = r_q[WIDTH-1:0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = dz_q;

endmodule : seq_restoring_divider

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: protocol-level reference model
// plus directed vectors and an exhaustive held-start sweep.
module tb_seq_restoring_divider;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = 4'd0;
    logic [WIDTH-1:0] divisor = 4'd0;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;

    int n_checks = 0;
    int n_errors = 0;

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .remainder(remainder),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: tracks handshake timing and results with plain arithmetic.
    bit               m_on = 1'b0;
    bit               m_busy, m_done, m_dz, m_known;
    logic [WIDTH-1:0] m_a, m_b, m_q, m_r;
    int               m_left;

    always @(posedge clk) begin
        if (rst) begin
            m_on    <= 1'b1;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_dz    <= 1'b0;
            m_q     <= 4'd0;
            m_r     <= 4'd0;
            m_known <= 1'b1;
            m_left  <= 0;
        end else if (m_on) begin
            if (!m_busy && start) begin
                m_a <= dividend;
                m_b <= divisor;
                if (divisor == 4'd0) begin
                    m_done  <= 1'b1;
                    m_dz    <= 1'b1;
                    m_q     <= 4'hF;
                    m_r     <= dividend;
                    m_known <= 1'b1;
                end else begin
                    m_done  <= 1'b0;
                    m_dz    <= 1'b0;
                    m_busy  <= 1'b1;
                    m_left  <= WIDTH;
                    m_known <= 1'b0;
                end
            end else if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy  <= 1'b0;
                    m_done  <= 1'b1;
                    m_q     <= m_a / m_b;
                    m_r     <= m_a % m_b;
                    m_known <= 1'b1;
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_on) begin
            check("busy", int'(busy), int'(m_busy));
            check("done", int'(done), int'(m_done));
            if (m_known) begin
                check("quotient", int'(quotient), int'(m_q));
                check("remainder", int'(remainder), int'(m_r));
                check("div_zero", int'(div_zero), int'(m_dz));
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        check("done_timeout", int'(done), 1);
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               q;
        int               r;
    } vec_t;

    vec_t vecs[4] = '{
        '{4'd13, 4'd3,  4, 1},
        '{4'd15, 4'd1, 15, 0},
        '{4'd2,  4'd7,  0, 2},
        '{4'd15, 4'd15, 1, 0}
    };

    initial begin
        int cyc;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_div_zero", int'(div_zero), 0);

        // Directed divides: literal results and exact latency.
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b);
            check("busy_after_accept", int'(busy), 1);
            wait_done(cyc);
            check("latency", cyc, WIDTH);
            check("vec_quotient", int'(quotient), vecs[i].q);
            check("vec_remainder", int'(remainder), vecs[i].r);
            check("vec_div_zero", int'(div_zero), 0);
            @(negedge clk);
        end

        // Divide by zero completes on the accepting edge.
        issue(4'd9, 4'd0);
        check("dz_done", int'(done), 1);
        check("dz_flag", int'(div_zero), 1);
        check("dz_quotient", int'(quotient), 15);
        check("dz_remainder", int'(remainder), 9);
        check("dz_busy", int'(busy), 0);
        repeat (2) @(negedge clk);

        // Start during CALC is ignored; operand changes have no effect.
        issue(4'd11, 4'd4);
        @(negedge clk);
        issue(4'd7, 4'd2);
        dividend = 4'd5;
        divisor  = 4'd1;
        wait_done(cyc);
        check("ign_quotient", int'(quotient), 2);
        check("ign_remainder", int'(remainder), 3);

        // Reset mid-CALC, then a clean divide.
        issue(4'd9, 4'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_quotient", int'(quotient), 0);
        check("mid_rst_remainder", int'(remainder), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_div_zero", int'(div_zero), 0);
        issue(4'd6, 4'd4);
        wait_done(cyc);
        check("post_rst_quotient", int'(quotient), 1);
        check("post_rst_remainder", int'(remainder), 2);

        // Exhaustive sweep with start held high.
        start = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                dividend = 4'(a);
                divisor  = 4'(b);
                @(negedge clk);
                wait_done(cyc);
                if (b == 0) begin
                    check("sweep_dz_flag", int'(div_zero), 1);
                    check("sweep_dz_quotient", int'(quotient), 15);
                    check("sweep_dz_remainder", int'(remainder), a);
                end else begin
                    check("sweep_identity", int'(quotient) * b + int'(remainder), a);
                    check("sweep_rem_lt_div", int'(int'(remainder) < b), 1);
                    check("sweep_dz_clear", int'(div_zero), 0);
                end
            end
        end
        start = 1'b0;
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seq_restoring_divider
